// File: rtl/core_id_q.sv
// Instruction-decode queue: a small {pc,instr} FIFO feeding a registered decode
// stage with operand-mux selection, writeback forwarding and branch/trap flags.
package core_id_q_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  reg_addr_t;
    typedef logic [2:0]  flag_t;

    // Instruction layout: [31:26] opcode, [25:22] regd, [21:18] rega,
    // [17:14] regb, [13] i, [12] s, [11] reserved, [10:0] immediate.
    typedef enum logic [5:0] {
        OPCODE_NOP  = 6'd0,
        OPCODE_ADD  = 6'd1,
        OPCODE_SUB  = 6'd2,
        OPCODE_AND  = 6'd3,
        OPCODE_OR   = 6'd4,
        OPCODE_MOV  = 6'd5,
        OPCODE_LD   = 6'd6,
        OPCODE_ST   = 6'd7,
        OPCODE_B    = 6'd8,
        OPCODE_CALL = 6'd9,
        OPCODE_RET  = 6'd10,
        OPCODE_RFE  = 6'd11,
        OPCODE_SWI  = 6'd12
    } opcode_t;

    typedef enum logic [1:0] {
        OPMUX_A_RA = 2'd0,
        OPMUX_A_PC = 2'd1,
        OPMUX_A_WB = 2'd2
    } opmux_a_t;

    typedef enum logic [1:0] {
        OPMUX_B_RB  = 2'd0,
        OPMUX_B_IMM = 2'd1,
        OPMUX_B_PC  = 2'd2,
        OPMUX_B_WB  = 2'd3
    } opmux_b_t;

    localparam reg_addr_t RF_PC = 4'hF;
endpackage

module core_id_q
    import core_id_q_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NWB   = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int FW = (NWB > 1) ? $clog2(NWB) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  addr_t                 if_pc,
    input  instr_t                if_instr,
    output logic                  id_valid,
    input  logic                  ex_ready,
    output addr_t                 id_pc,
    output instr_t                id_instr,
    input  logic                  id_flush,
    input  logic [NWB-1:0]        wb_valid,
    input  reg_addr_t [NWB-1:0]   wb_addr,
    input  flag_t                 flag,
    output reg_addr_t             rega_addr,
    output reg_addr_t             regb_addr,
    output data_t                 imm,
    output opmux_a_t              opmux_a,
    output opmux_b_t              opmux_b,
    output logic [FW-1:0]         fwd_sel_a,
    output logic [FW-1:0]         fwd_sel_b,
    output logic                  branch,
    output logic                  branch_imm,
    output logic                  branch_abs,
    output logic                  rfe,
    output logic                  swi,
    output logic                  wb_spr,
    output logic                  id_err,
    output reg_addr_t             spr_addr,
    output logic [CW-1:0]         id_count
);

    addr_t         q_pc    [DEPTH];
    instr_t        q_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic   enq, load, deq, wr, src_valid;
    addr_t  src_pc;
    instr_t src_instr;

    assign if_ready  = (id_count < CW'(DEPTH)) && !id_flush;
    assign enq       = if_valid && if_ready;
    assign load      = !id_valid || ex_ready;
    assign deq       = load && (id_count != '0);
    // With an empty queue and the output loading, the new entry bypasses storage.
    assign wr        = enq && !(load && (id_count == '0));
    assign src_valid = (id_count != '0) || enq;
    assign src_pc    = (id_count != '0) ? q_pc[rd_ptr]    : if_pc;
    assign src_instr = (id_count != '0) ? q_instr[rd_ptr] : if_instr;

    logic [5:0]    s_op;
    reg_addr_t     s_regd, s_rega, s_regb;
    logic          s_i, s_s;
    logic          unused_rsvd;
    data_t         d_imm;
    opmux_a_t      d_oa;
    opmux_b_t      d_ob;
    logic [FW-1:0] d_fa, d_fb, a_k, b_k;
    logic          a_hit, b_hit, d_br, d_rfe, d_swi, d_wspr, d_err;

    function automatic logic is_opcode(input logic [5:0] op);
        case (op)
            OPCODE_NOP, OPCODE_ADD, OPCODE_SUB, OPCODE_AND, OPCODE_OR,
            OPCODE_MOV, OPCODE_LD, OPCODE_ST, OPCODE_B, OPCODE_CALL,
            OPCODE_RET, OPCODE_RFE, OPCODE_SWI: is_opcode = 1'b1;
            default:                            is_opcode = 1'b0;
        endcase
    endfunction

    assign s_op        = src_instr[31:26];
    assign s_regd      = src_instr[25:22];
    assign s_rega      = src_instr[21:18];
    assign s_regb      = src_instr[17:14];
    assign s_i         = src_instr[13];
    assign s_s         = src_instr[12];
    assign unused_rsvd = src_instr[11];

    always_comb begin
        d_imm = '0;
        if (s_i)
            d_imm = s_s ? {{21{src_instr[10]}}, src_instr[10:0]} : {21'd0, src_instr[10:0]};

        // Scan downward so the lowest matching port is the one that sticks.
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_k   = '0;
        b_k   = '0;
        for (int k = NWB - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_addr[k] == s_rega)) begin
                a_hit = 1'b1;
                a_k   = FW'(k);
            end
            if (wb_valid[k] && (wb_addr[k] == s_regb)) begin
                b_hit = 1'b1;
                b_k   = FW'(k);
            end
        end

        d_fa = '0;
        if (s_rega == RF_PC) begin
            d_oa = OPMUX_A_PC;
        end else if (a_hit) begin
            d_oa = OPMUX_A_WB;
            d_fa = a_k;
        end else begin
            d_oa = OPMUX_A_RA;
        end

        d_fb = '0;
        if (s_i) begin
            d_ob = OPMUX_B_IMM;
        end else if (s_regb == RF_PC) begin
            d_ob = OPMUX_B_PC;
        end else if (b_hit) begin
            d_ob = OPMUX_B_WB;
            d_fb = b_k;
        end else begin
            d_ob = OPMUX_B_RB;
        end

        case (s_op)
            OPCODE_B:               d_br = (s_regd[2:0] == flag);
            OPCODE_CALL, OPCODE_RET: d_br = 1'b1;
            default:                d_br = 1'b0;
        endcase
        d_rfe  = (s_op == OPCODE_RFE);
        d_swi  = (s_op == OPCODE_SWI);
        d_wspr = (s_op == OPCODE_MOV) && s_regb[1];
        d_err  = !is_opcode(s_op);
    end

    // Queue storage carries no reset; the pointers and count alone define contents.
    always_ff @(posedge clk) begin
        if (wr) begin
            q_pc[wr_ptr]    <= if_pc;
            q_instr[wr_ptr] <= if_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            id_count  <= '0;
            id_valid  <= 1'b0;
            id_pc     <= '0;
            id_instr  <= {OPCODE_NOP, 26'd0};
            imm       <= '0;
            opmux_a   <= OPMUX_A_RA;
            opmux_b   <= OPMUX_B_RB;
            fwd_sel_a <= '0;
            fwd_sel_b <= '0;
            branch    <= 1'b0;
            rfe       <= 1'b0;
            swi       <= 1'b0;
            wb_spr    <= 1'b0;
            id_err    <= 1'b0;
        end else if (id_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            id_count  <= '0;
            id_valid  <= 1'b0;
            id_instr  <= {OPCODE_NOP, 26'd1};
            imm       <= '0;
            opmux_a   <= OPMUX_A_RA;
            opmux_b   <= OPMUX_B_RB;
            fwd_sel_a <= '0;
            fwd_sel_b <= '0;
            branch    <= 1'b0;
            rfe       <= 1'b0;
            swi       <= 1'b0;
            wb_spr    <= 1'b0;
            id_err    <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr, deq})
                2'b10:   id_count <= id_count + 1'b1;
                2'b01:   id_count <= id_count - 1'b1;
                default: id_count <= id_count;
            endcase

            if (load) begin
                id_valid <= src_valid;
                branch   <= src_valid && d_br;
                rfe      <= src_valid && d_rfe;
                swi      <= src_valid && d_swi;
                wb_spr   <= src_valid && d_wspr;
                id_err   <= src_valid && d_err;
                if (src_valid) begin
                    id_pc     <= src_pc;
                    id_instr  <= src_instr;
                    imm       <= d_imm;
                    opmux_a   <= d_oa;
                    opmux_b   <= d_ob;
                    fwd_sel_a <= d_fa;
                    fwd_sel_b <= d_fb;
                end
            end
        end
    end

    assign rega_addr  = id_instr[21:18];
    assign regb_addr  = id_instr[17:14];
    assign spr_addr   = id_instr[25:22];
    assign branch_imm = id_instr[13];
    assign branch_abs = id_instr[14];

endmodule

// File: tb/tb_core_id_q.sv
// Directed bench for core_id_q: a list-of-outstanding-instructions model checked
// every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_core_id_q;
    import core_id_q_pkg::*;

    localparam int DEPTH = 4;
    localparam int NWB   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                if_valid, if_ready, id_valid, ex_ready, id_flush;
    addr_t               if_pc, id_pc;
    instr_t              if_instr, id_instr;
    logic [NWB-1:0]      wb_valid;
    reg_addr_t [NWB-1:0] wb_addr;
    flag_t               flag;
    reg_addr_t           rega_addr, regb_addr, spr_addr;
    data_t               imm;
    opmux_a_t            opmux_a;
    opmux_b_t            opmux_b;
    logic [0:0]          fwd_sel_a, fwd_sel_b;
    logic                branch, branch_imm, branch_abs, rfe, swi, wb_spr, id_err;
    logic [2:0]          id_count;

    int n_checks = 0;
    int n_fail   = 0;

    core_id_q #(.DEPTH(DEPTH), .NWB(NWB)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc), .id_instr(id_instr),
        .id_flush(id_flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .flag(flag),
        .rega_addr(rega_addr), .regb_addr(regb_addr), .imm(imm),
        .opmux_a(opmux_a), .opmux_b(opmux_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .branch(branch), .branch_imm(branch_imm), .branch_abs(branch_abs),
        .rfe(rfe), .swi(swi), .wb_spr(wb_spr), .id_err(id_err),
        .spr_addr(spr_addr), .id_count(id_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, imm;
        logic [1:0]  oa, ob;
        logic        fa, fb, br, rfe, swi, wspr, err;
    } ent_t;

    // Every accepted, not yet consumed instruction; element 0 sits at the outputs.
    ent_t lst[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic i, input logic s, input logic [10:0] im);
        return {op, rd, ra, rb, i, s, 1'b0, im};
    endfunction

    function automatic ent_t decode(input logic [31:0] pc, input logic [31:0] ins);
        ent_t e;
        logic [5:0] op;
        logic [3:0] rd, ra, rb;
        logic       i, s;
        int         ka, kb;
        op = ins[31:26]; rd = ins[25:22]; ra = ins[21:18]; rb = ins[17:14];
        i = ins[13]; s = ins[12];
        e.pc = pc; e.instr = ins;
        if (!i)     e.imm = 32'd0;
        else if (s) e.imm = 32'(signed'(ins[10:0]));
        else        e.imm = 32'(ins[10:0]);
        ka = -1; kb = -1;
        for (int k = 0; k < NWB; k++) begin
            if (ka < 0 && wb_valid[k] && wb_addr[k] == ra) ka = k;
            if (kb < 0 && wb_valid[k] && wb_addr[k] == rb) kb = k;
        end
        e.fa = 1'b0; e.fb = 1'b0;
        if (ra == RF_PC)  e.oa = OPMUX_A_PC;
        else if (ka >= 0) begin e.oa = OPMUX_A_WB; e.fa = (ka == 1); end
        else              e.oa = OPMUX_A_RA;
        if (i)              e.ob = OPMUX_B_IMM;
        else if (rb == RF_PC) e.ob = OPMUX_B_PC;
        else if (kb >= 0) begin e.ob = OPMUX_B_WB; e.fb = (kb == 1); end
        else              e.ob = OPMUX_B_RB;
        e.br   = (op == 6'd8) ? (rd[2:0] == flag) : (op == 6'd9 || op == 6'd10);
        e.rfe  = (op == 6'd11);
        e.swi  = (op == 6'd12);
        e.wspr = (op == 6'd5) && rb[1];
        e.err  = (op > 6'd12);
        return e;
    endfunction

    function automatic int queued();
        return (lst.size() > 0) ? lst.size() - 1 : 0;
    endfunction

    task automatic model_step();
        logic acc, pop, fresh;
        if (!rst || id_flush) begin
            lst.delete();
            return;
        end
        acc   = if_valid && (queued() < DEPTH);
        pop   = (lst.size() > 0) && ex_ready;
        fresh = pop || (lst.size() == 0);
        if (pop) void'(lst.pop_front());
        if (acc) lst.push_back(decode(if_pc, if_instr));
        if (fresh && lst.size() > 0) lst[0] = decode(lst[0].pc, lst[0].instr);
    endtask

    task automatic compare();
        ent_t e;
        if (!rst) begin
            chk("rst_id_valid", id_valid, 0);
            chk("rst_id_count", id_count, 0);
            chk("rst_id_pc", id_pc, 0);
            chk("rst_id_instr", id_instr, 0);
            chk("rst_imm", imm, 0);
            chk("rst_opmux", {opmux_a, opmux_b}, {OPMUX_A_RA, OPMUX_B_RB});
            chk("rst_fwd", {fwd_sel_a, fwd_sel_b}, 0);
            chk("rst_flags", {branch, branch_imm, branch_abs, rfe, swi, wb_spr, id_err}, 0);
            return;
        end
        chk("id_valid", id_valid, lst.size() > 0);
        chk("id_count", id_count, queued());
        chk("if_ready", if_ready, (queued() < DEPTH) && !id_flush);
        if (lst.size() > 0) begin
            e = lst[0];
            chk("id_pc", id_pc, e.pc);
            chk("id_instr", id_instr, e.instr);
            chk("imm", imm, e.imm);
            chk("opmux_a", opmux_a, e.oa);
            chk("opmux_b", opmux_b, e.ob);
            chk("fwd_sel_a", fwd_sel_a, e.fa);
            chk("fwd_sel_b", fwd_sel_b, e.fb);
            chk("branch", branch, e.br);
            chk("rfe_swi_spr_err", {rfe, swi, wb_spr, id_err}, {e.rfe, e.swi, e.wspr, e.err});
            chk("reg_addrs", {rega_addr, regb_addr, spr_addr}, {e.instr[21:18], e.instr[17:14], e.instr[25:22]});
            chk("branch_imm_abs", {branch_imm, branch_abs}, {e.instr[13], e.instr[14]});
        end else begin
            chk("idle_flags", {branch, rfe, swi, wb_spr, id_err}, 0);
        end
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); compare(); end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] ins);
        if_valid = 1'b1; if_pc = pc; if_instr = ins;
        cyc();
    endtask

    initial begin
        int got;
        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        ex_ready = 1'b1; id_flush = 1'b0; wb_valid = '0; wb_addr = '0; flag = '0;
        repeat (2) cyc();
        chk("lit_rst_valid", id_valid, 0);
        chk("lit_rst_instr", id_instr, 32'h0000_0000);
        rst = 1'b1;
        cyc();
        chk("lit_if_ready_after_rst", if_ready, 1);

        put(32'h100, mk(OPCODE_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 11'h7FF));
        if_valid = 1'b0;
        chk("lit_latency_valid", id_valid, 1);
        chk("lit_imm_sext", imm, 32'hFFFF_FFFF);
        chk("lit_opb_imm", opmux_b, OPMUX_B_IMM);
        put(32'h104, mk(OPCODE_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 11'h7FF));
        if_valid = 1'b0;
        chk("lit_imm_zext", imm, 32'h0000_07FF);

        wb_valid = 2'b11; wb_addr[0] = 4'd3; wb_addr[1] = 4'd3;
        put(32'h108, mk(OPCODE_ADD, 4'd1, 4'd3, 4'd5, 1'b0, 1'b0, 11'd0));
        if_valid = 1'b0;
        chk("lit_opa_wb", opmux_a, OPMUX_A_WB);
        chk("lit_fwd_a_lowest", fwd_sel_a, 0);
        chk("lit_opb_rb", opmux_b, OPMUX_B_RB);
        put(32'h10C, mk(OPCODE_ADD, 4'd1, RF_PC, 4'd3, 1'b0, 1'b0, 11'd0));
        if_valid = 1'b0;
        chk("lit_opa_pc", opmux_a, OPMUX_A_PC);
        chk("lit_opb_wb", opmux_b, OPMUX_B_WB);
        wb_valid = 2'b10; wb_addr[0] = 4'd5; wb_addr[1] = 4'd5;
        put(32'h110, mk(OPCODE_SUB, 4'd2, 4'd5, 4'd5, 1'b0, 1'b0, 11'd0));
        if_valid = 1'b0;
        chk("lit_fwd_a_port1", fwd_sel_a, 1);
        chk("lit_fwd_b_port1", fwd_sel_b, 1);
        wb_valid = 2'b00;

        flag = 3'b010;
        put(32'h120, mk(OPCODE_B, 4'b0010, 4'd0, 4'd0, 1'b1, 1'b0, 11'h010));
        chk("lit_branch_taken", branch, 1);
        flag = 3'b011;
        put(32'h124, mk(OPCODE_B, 4'b0010, 4'd0, 4'd0, 1'b1, 1'b0, 11'h010));
        chk("lit_branch_not_taken", branch, 0);
        put(32'h128, 32'hFC00_0000);
        chk("lit_id_err", id_err, 1);
        put(32'h12C, mk(OPCODE_RFE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0));
        chk("lit_rfe", rfe, 1);
        put(32'h130, mk(OPCODE_MOV, 4'd7, 4'd0, 4'b0010, 1'b0, 1'b0, 11'd0));
        if_valid = 1'b0;
        chk("lit_wb_spr", {wb_spr, spr_addr}, {1'b1, 4'd7});
        cyc();
        chk("lit_idle_err_forced", id_err, 0);

        ex_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            put(32'h200 + 32'(4 * i), mk(OPCODE_ADD, 4'(i), 4'(i), 4'(i), 1'b0, 1'b0, 11'(i)));
        if_valid = 1'b0;
        chk("lit_full_count", id_count, 4);
        chk("lit_full_if_ready", if_ready, 0);
        chk("lit_full_head", id_pc, 32'h200);
        ex_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 5; c++) begin
            if (id_valid) begin
                chk("lit_drain_order", id_pc, 32'h200 + 32'(4 * got));
                got++;
            end
            cyc();
        end
        chk("lit_drain_count", got, 5);

        ex_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            put(32'h300 + 32'(4 * i), mk(OPCODE_OR, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 11'd0));
        chk("lit_pre_flush_count", id_count, 3);
        id_flush = 1'b1; if_valid = 1'b1; if_pc = 32'hDEAD0;
        if_instr = mk(OPCODE_SWI, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 11'd0);
        cyc();
        id_flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        chk("lit_flush_count", id_count, 0);
        chk("lit_flush_valid", id_valid, 0);
        chk("lit_flush_instr", id_instr, 32'h0000_0001);
        repeat (3) cyc();
        chk("lit_flush_dropped", id_valid, 0);

        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            put(32'h400 + 32'(4 * i), mk(OPCODE_LD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 11'd0));
        if_valid = 1'b0;
        chk("lit_pre_rst_count", id_count, 2);
        #1 rst = 1'b0;
        #1;
        chk("lit_async_valid", id_valid, 0);
        chk("lit_async_count", id_count, 0);
        chk("lit_async_pc", id_pc, 0);
        chk("lit_async_instr", id_instr, 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("lit_rst_release_ready", if_ready, 1);
        chk("lit_rst_release_valid", id_valid, 0);

        for (int i = 0; i < 16; i++) begin
            ex_ready   = (i % 3) != 0;
            wb_valid   = 2'(i);
            wb_addr[0] = 4'(i);
            wb_addr[1] = 4'(i + 1);
            flag       = 3'(i);
            put(32'h500 + 32'(4 * i),
                mk(6'(i % 14), 4'(i), 4'(i + 1), 4'(15 - i), 1'(i % 5 == 0), 1'(i % 2), 11'(i * 37)));
        end
        if_valid = 1'b0; ex_ready = 1'b1;
        repeat (8) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/core_id_q.md
CORE_ID_Q -- requirements
Module: core_id_q

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, instruction queue entries (legal 2..8, power of two).
REQ-002 SHALL provide parameter NWB, default 2, number of writeback forwarding ports (legal 1..4).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have ports if_valid (in, 1), if_ready (out, 1), if_pc (in, addr_t) and if_instr (in, instr_t), forming the fetch-side handshake.
REQ-006 SHALL have ports id_valid (out, 1), ex_ready (in, 1), id_pc (out, addr_t) and id_instr (out, instr_t), forming the execute-side handshake.
REQ-007 SHALL have port id_flush, input, 1, synchronous pipeline flush.
REQ-008 SHALL have wb_valid (in, NWB) and wb_addr (in, NWB x reg_addr_t, port k at slice k), and flag (in, flag_t).
REQ-009 SHALL have rega_addr and regb_addr (out, reg_addr_t), taken from the id_instr fields.
REQ-010 SHALL have imm (out, data_t), opmux_a (out, opmux_a_t), opmux_b (out, opmux_b_t), fwd_sel_a and fwd_sel_b (out, $clog2(NWB) min 1).
REQ-011 SHALL have branch, branch_imm, branch_abs, rfe, swi, wb_spr and id_err (out, 1 each), spr_addr (out, reg_addr_t), and id_count (out, $clog2(DEPTH)+1).

Function
REQ-012 Queue SHALL be a DEPTH-entry FIFO of {pc,instr}: circular read/write pointers, occupancy counter id_count.
REQ-013 if_ready SHALL be 1 when id_count<DEPTH and id_flush=0; enqueue occurs when if_valid&&if_ready.
REQ-014 The output register (id_valid,id_pc,id_instr and all decode outputs) SHALL load when id_valid=0 or ex_ready=1.
REQ-015 On load, the output register SHALL take the queue head if id_count>0; otherwise it SHALL take the current enqueue directly (bypass).
REQ-016 Latency SHALL be 1 cycle: on an empty, idle block, an instruction accepted at edge N is valid at id outputs after edge N.
REQ-017 Simultaneous enqueue and dequeue SHALL leave id_count unchanged, and pointers SHALL wrap modulo DEPTH.
REQ-018 id_valid=1 with ex_ready=0 SHALL hold all id outputs stable.
REQ-019 id_flush=1 SHALL empty the queue at the next edge (pointers=0, id_count=0), set id_valid=0 and id_instr={OPCODE_NOP,26'd1}, and drop any same-cycle input; flush SHALL win over all events.
REQ-020 imm SHALL be computed from the instruction being loaded, in the same cycle as id_instr: i=1,s=1 gives sign-extend of instr[10:0]; i=1,s=0 gives zero-extend; i=0 gives 0.
REQ-021 opmux_a SHALL be selected by priority: rega==RF_PC gives OPMUX_A_PC; else a match on any k with wb_valid[k]&&wb_addr[k]==rega gives OPMUX_A_WB with fwd_sel_a=lowest matching k; else OPMUX_A_RA.
REQ-022 opmux_b SHALL be selected by priority: i=1 gives OPMUX_B_IMM; regb==RF_PC gives OPMUX_B_PC; a writeback match on regb gives OPMUX_B_WB with fwd_sel_b=lowest k; else OPMUX_B_RB.
REQ-023 Forwarding compare SHALL use the wb inputs sampled in the load cycle, and fwd_sel SHALL be 0 when the path is not WB.
REQ-024 branch SHALL be: OPCODE_B gives (regd_cond[2:0]==flag); OPCODE_CALL and OPCODE_RET give 1; all others give 0.
REQ-025 branch_imm SHALL equal i and branch_abs SHALL equal regb[0].
REQ-026 rfe SHALL equal (opcode==OPCODE_RFE) and swi SHALL equal (opcode==OPCODE_SWI).
REQ-027 wb_spr SHALL equal (opcode==OPCODE_MOV && regb[1]), and spr_addr SHALL equal regd.
REQ-028 id_err SHALL be 1 when the opcode is not a member of opcode_t.
REQ-029 branch, rfe, swi, wb_spr and id_err SHALL be forced to 0 whenever id_valid=0.

Reset
REQ-030 While rst=0, all pointers and id_count SHALL be 0 and id_valid=0.
REQ-031 While rst=0, id_pc SHALL be 0 and id_instr={OPCODE_NOP,26'd0}.
REQ-032 While rst=0, imm, fwd_sel_a, fwd_sel_b and all 1-bit decode outputs SHALL be 0.
REQ-033 While rst=0, opmux_a SHALL be OPMUX_A_RA and opmux_b SHALL be OPMUX_B_RB.
REQ-034 if_ready SHALL be 1 from the first edge after rst deasserts.
REQ-035 Reset asserted mid-operation SHALL discard queued entries immediately, without waiting for a clock.

Verification
REQ-036 Empty queue, one ADD with i=1,s=1,instr[10:0]=11'h7FF -> next cycle id_valid=1, imm=32'hFFFFFFFF, opmux_b=OPMUX_B_IMM.
REQ-037 ex_ready=0 with 5 back-to-back inputs (DEPTH=4) -> 1 held at output and 4 queued, id_count=4, if_ready=0; then ex_ready=1 -> all 5 emerge in order with no loss.
REQ-038 Queue holds 3 entries, id_flush=1 with if_valid=1 -> next cycle id_count=0, id_valid=0, id_instr={OPCODE_NOP,26'd1}, and the flushed input never appears.
REQ-039 rega=3, wb_valid=2'b11, wb_addr[0]=3, wb_addr[1]=3 -> opmux_a=OPMUX_A_WB, fwd_sel_a=0; rega=RF_PC with the same wb -> OPMUX_A_PC.
REQ-040 OPCODE_B with regd_cond[2:0]=flag=3'b010 -> branch=1; flag=3'b011 -> branch=0; undefined opcode -> id_err=1.
REQ-041 rst pulsed low mid-stream with 2 entries queued -> outputs at reset values asynchronously, if_ready=1 after release.
